// File: rtl/message_stream_arbiter_if.sv
// Bundle of producer-side and sink-side message-stream signals for message_stream_arbiter.
// Handshake: a word moves on a rising edge where valid && ready; valid never waits on ready.
interface message_stream_arbiter_if #(
  parameter int N_STREAMS    = 4,
  parameter int WIDTH        = 32,
  parameter int WEIGHT_WIDTH = 4
);
  logic [WIDTH*N_STREAMS-1:0]        in_data;
  logic [N_STREAMS-1:0]              in_valid;
  logic [N_STREAMS-1:0]              in_ready;
  logic [WEIGHT_WIDTH*N_STREAMS-1:0] in_weights;
  logic [WIDTH-1:0]                  out_data;
  logic                              out_valid;
  logic                              out_ready;
  logic [N_STREAMS-1:0]              grant;
  logic                              error;

  modport master (
    output in_data, in_valid, in_weights, out_ready,
    input  in_ready, out_data, out_valid, grant, error
  );

  modport slave (
    input  in_data, in_valid, in_weights, out_ready,
    output in_ready, out_data, out_valid, grant, error
  );
endinterface

// File: rtl/message_stream_arbiter.sv
// Packet-level round-robin arbiter: one whole packet per grant, header-length framed.
// Define MSA_WEIGHTED_EN to grant several consecutive packets per stream by weight.
module message_stream_arbiter #(
  parameter int N_STREAMS             = 4,
  parameter int LOG_N_STREAMS         = 2,
  parameter int WIDTH                 = 32,
  parameter int LOG_MAX_PACKET_LENGTH = 10,
  parameter int WEIGHT_WIDTH          = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  message_stream_arbiter_if.slave       bus,
  output logic [1:0]                    dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HEAD = 2'd1, S_BODY = 2'd2} state_t;

  state_t                           state_q, state_d;
  logic [N_STREAMS-1:0]             grant_q, grant_d;
  logic [LOG_N_STREAMS-1:0]         ptr_q, ptr_d;
  logic [LOG_MAX_PACKET_LENGTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0]                 out_data_q, out_data_d;
  logic                             out_valid_q, out_valid_d;
  logic                             error_q, error_d;

  logic [LOG_N_STREAMS-1:0]         gidx;
  logic [WIDTH-1:0]                 word;
  logic [N_STREAMS-1:0]             in_ready_w;
  logic                             accept;
  logic                             pkt_done;
  logic                             turn_done;
  logic                             found;
  logic [LOG_N_STREAMS-1:0]         sel_idx;
  logic [LOG_N_STREAMS:0]           cand;

`ifdef MSA_WEIGHTED_EN
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
  logic [WEIGHT_WIDTH-1:0] weight_q, weight_d;
  logic [WEIGHT_WIDTH-1:0] eff_weight;
`else
  logic unused_weights;
  assign unused_weights = ^bus.in_weights;
`endif

  // Owner index and its current word, selected from the one-hot grant.
  always_comb begin
    gidx = '0;
    word = '0;
    for (int i = 0; i < N_STREAMS; i++) begin
      if (grant_q[i]) begin
        gidx = LOG_N_STREAMS'(i);
        word = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // The output register can take a new word when it is empty or being drained.
  always_comb begin
    in_ready_w = '0;
    if (state_q != S_IDLE && (!out_valid_q || bus.out_ready)) in_ready_w = grant_q;
  end

  assign accept = |(bus.in_valid & in_ready_w);

`ifdef MSA_WEIGHTED_EN
  assign eff_weight = (weight_q == '0) ? WEIGHT_WIDTH'(1) : weight_q;
  assign turn_done  = ({1'b0, credit_q} + (WEIGHT_WIDTH+1)'(1)) >= {1'b0, eff_weight};
`else
  assign turn_done  = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    error_d     = 1'b0;
    pkt_done    = 1'b0;
    found       = 1'b0;
    sel_idx     = '0;
    cand        = '0;
`ifdef MSA_WEIGHTED_EN
    credit_d    = credit_q;
    weight_d    = weight_q;
`endif
    case (state_q)
      S_IDLE: begin
        // First valid stream at or after ptr, wrapping.
        for (int k = 0; k < N_STREAMS; k++) begin
          cand = {1'b0, ptr_q} + (LOG_N_STREAMS+1)'(k);
          if (cand >= (LOG_N_STREAMS+1)'(N_STREAMS)) cand = cand - (LOG_N_STREAMS+1)'(N_STREAMS);
          if (!found && bus.in_valid[cand[LOG_N_STREAMS-1:0]]) begin
            found   = 1'b1;
            sel_idx = cand[LOG_N_STREAMS-1:0];
          end
        end
        if (found) begin
          grant_d = {{(N_STREAMS-1){1'b0}}, 1'b1} << sel_idx;
          state_d = S_HEAD;
`ifdef MSA_WEIGHTED_EN
          if (sel_idx != ptr_q) credit_d = '0;
          for (int i = 0; i < N_STREAMS; i++) begin
            if (sel_idx == LOG_N_STREAMS'(i)) weight_d = bus.in_weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
          end
`endif
        end
      end
      S_HEAD: begin
        if (accept) begin
          if (word[WIDTH-1]) begin
            out_data_d  = word;
            out_valid_d = 1'b1;
            remaining_d = word[WIDTH-2 -: LOG_MAX_PACKET_LENGTH];
            if (word[WIDTH-2 -: LOG_MAX_PACKET_LENGTH] == '0) pkt_done = 1'b1;
            else state_d = S_BODY;
          end else begin
            // Malformed header is dropped; the stream keeps its place in the rotation.
            error_d = 1'b1;
            grant_d = '0;
            state_d = S_IDLE;
          end
        end
      end
      S_BODY: begin
        if (accept) begin
          out_data_d  = word;
          out_valid_d = 1'b1;
          remaining_d = remaining_q - LOG_MAX_PACKET_LENGTH'(1);
          if (remaining_q == LOG_MAX_PACKET_LENGTH'(1)) pkt_done = 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase

    if (pkt_done) begin
      grant_d = '0;
      state_d = S_IDLE;
      if (turn_done) begin
        ptr_d = (gidx == LOG_N_STREAMS'(N_STREAMS-1)) ? '0 : gidx + LOG_N_STREAMS'(1);
`ifdef MSA_WEIGHTED_EN
        credit_d = '0;
      end else begin
        credit_d = credit_q + WEIGHT_WIDTH'(1);
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      error_q     <= error_d;
    end
  end

`ifdef MSA_WEIGHTED_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_q <= '0;
      weight_q <= '0;
    end else begin
      credit_q <= credit_d;
      weight_q <= weight_d;
    end
  end
`endif

  assign bus.in_ready  = in_ready_w;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.grant     = grant_q;
  assign bus.error     = error_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_message_stream_arbiter.sv
// Directed bench for message_stream_arbiter: per-stream word sources, an expected-word
// queue filled at load time, and a monitor that pops it on every output handshake.
module tb_message_stream_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int WW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  message_stream_arbiter_if #(.N_STREAMS(N), .WIDTH(W), .WEIGHT_WIDTH(WW)) bus ();

  message_stream_arbiter #(
    .N_STREAMS(N), .LOG_N_STREAMS(2), .WIDTH(W),
    .LOG_MAX_PACKET_LENGTH(10), .WEIGHT_WIDTH(WW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  logic [W-1:0] exp_q[$];
  int           n_cmp  = 0;
  int           n_fail = 0;

  logic [W-1:0] src_mem [N][16];
  int           src_wr [N];
  int           src_rd [N];
  logic [N-1:0] fire;

  function automatic logic [W-1:0] hdr(input int l, input int s, input int n);
    logic [W-1:0] r;
    r        = '0;
    r[31]    = 1'b1;
    r[30:21] = l[9:0];
    r[7:4]   = s[3:0];
    r[3:0]   = n[3:0];
    return r;
  endfunction

  function automatic logic [W-1:0] pay(input int s, input int n);
    logic [W-1:0] r;
    r       = '0;
    r[15:8] = s[7:0];
    r[7:0]  = n[7:0];
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic put(input int s, input logic [W-1:0] w, input bit expect_out);
    src_mem[s][src_wr[s]] = w;
    src_wr[s]++;
    if (expect_out) exp_q.push_back(w);
  endtask

  // Source driver: handshake sampled mid-cycle, sources advanced just after the edge.
  initial begin
    fire = '0;
    forever begin
      @(negedge clk);
      fire = bus.in_valid & bus.in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fire[i] && !rst) src_rd[i]++;
        bus.in_valid[i]          = (src_rd[i] < src_wr[i]);
        bus.in_data[W*i +: W]    = src_mem[i][src_rd[i] % 16];
      end
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL out_word_unexpected: got %h, none expected at %0t", bus.out_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_word", bus.out_data, e);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    check("drained_before_reset", exp_q.size(), 0);
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_grant", bus.grant, 0);
    check("rst_error", bus.error, 0);
    check("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int           n_valid;
    int           n_idle;
    int           budget;
    logic [7:0]   pat;
    logic         held_valid;
    logic [W-1:0] held;

    rst            = 1'b1;
    bus.out_ready  = 1'b1;
    bus.in_valid   = '0;
    bus.in_data    = '0;
    bus.in_weights = {4'd3, 4'd0, 4'd2, 4'd1};

    // Single stream, L=3.
    do_reset();
    put(0, hdr(3, 0, 0), 1);
    for (int n = 1; n <= 3; n++) put(0, pay(0, n), 1);
    repeat (2) @(negedge clk);
    check("t1_grant", bus.grant, 4'b0001);
    check("t1_in_ready", bus.in_ready, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t1_consecutive_valid", bus.out_valid, 1);
    end
    check("t1_grant_clear", bus.grant, 0);
    @(negedge clk);
    check("t1_valid_clear", bus.out_valid, 0);
    drain("t1_drain");

`ifndef MSA_WEIGHTED_EN
    // Round robin, all streams valid, L=1 packets.
    do_reset();
    for (int s = 0; s < N; s++) begin
      put(s, hdr(1, s, 0), 0);
      put(s, pay(s, 0), 0);
      put(s, hdr(1, s, 1), 0);
      put(s, pay(s, 1), 0);
    end
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < N; s++) begin
        exp_q.push_back(hdr(1, s, r));
        exp_q.push_back(pay(s, r));
      end
    end
    budget = 0;
    while (!bus.out_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("t2_first_valid_seen", bus.out_valid, 1);
    n_valid = 1;
    n_idle  = 0;
    budget  = 0;
    while (n_valid < 16 && budget < 60) begin
      @(negedge clk);
      budget++;
      if (bus.out_valid) n_valid++;
      else n_idle++;
    end
    check("t2_idle_gaps", n_idle, 7);
    drain("t2_drain");
`else
    // Weighted: weights {1,2,0,3}, header-only packets.
    do_reset();
    put(0, hdr(0, 0, 0), 0);
    put(1, hdr(0, 1, 0), 0);
    put(1, hdr(0, 1, 1), 0);
    put(2, hdr(0, 2, 0), 0);
    put(3, hdr(0, 3, 0), 0);
    put(3, hdr(0, 3, 1), 0);
    put(3, hdr(0, 3, 2), 0);
    exp_q.push_back(hdr(0, 0, 0));
    exp_q.push_back(hdr(0, 1, 0));
    exp_q.push_back(hdr(0, 1, 1));
    exp_q.push_back(hdr(0, 2, 0));
    exp_q.push_back(hdr(0, 3, 0));
    exp_q.push_back(hdr(0, 3, 1));
    exp_q.push_back(hdr(0, 3, 2));
    drain("tw_drain");
`endif

    // Bad header on stream 2.
    do_reset();
    put(2, 32'h0000_0005, 0);
    put(2, hdr(0, 2, 1), 1);
    repeat (2) @(negedge clk);
    check("t3_grant", bus.grant, 4'b0100);
    @(negedge clk);
    check("t3_error_pulse", bus.error, 1);
    check("t3_no_out_valid", bus.out_valid, 0);
    check("t3_grant_dropped", bus.grant, 0);
    @(negedge clk);
    check("t3_error_clear", bus.error, 0);
    check("t3_regrant", bus.grant, 4'b0100);
    drain("t3_drain");

    // Output stalls inside an L=4 body.
    do_reset();
    put(0, hdr(4, 0, 0), 1);
    for (int n = 0; n < 4; n++) put(0, pay(0, n), 1);
    repeat (2) @(negedge clk);
    check("t4_grant", bus.grant, 4'b0001);
    pat        = 8'b1111_0011;
    held_valid = 1'b0;
    held       = '0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      bus.out_ready = pat[c];
      @(negedge clk);
      if (held_valid) check("t4_hold_data", bus.out_data, held);
      if (!bus.out_ready) check("t4_in_ready_stall", bus.in_ready, 0);
      held_valid = bus.out_valid && !bus.out_ready;
      held       = bus.out_data;
    end
    bus.out_ready = 1'b1;
    drain("t4_drain");

    // Reset in BODY with two payload words outstanding.
    do_reset();
    put(0, hdr(4, 0, 0), 1);
    put(0, pay(0, 0), 1);
    put(0, pay(0, 1), 1);
    put(0, pay(0, 2), 0);
    put(0, pay(0, 3), 0);
    repeat (5) @(negedge clk);
    check("t5_in_body", dbg_state, 2'd2);
    #1;
    rst = 1'b1;
    #1;
    check("t5_async_out_valid", bus.out_valid, 0);
    check("t5_async_grant", bus.grant, 0);
    check("t5_async_error", bus.error, 0);
    do_reset();
    put(1, hdr(1, 1, 0), 1);
    put(1, pay(1, 0), 1);
    repeat (2) @(negedge clk);
    check("t5_regrant_s1", bus.grant, 4'b0010);
    drain("t5_drain");

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/message_stream_arbiter.md
# message_stream_arbiter

Packet-level arbiter that shares one message-stream output between N_STREAMS upstream producers with valid/ready handshaking. It parses each message header, holds the grant for exactly one whole packet, then moves on in round-robin order, optionally granting several consecutive packets per stream according to a per-stream weight. It sits between per-source message generators and a single shared message sink, such as a DMA or FIFO, and is the backpressured counterpart of the buffered stream combiner.

## Interface
- N_STREAMS, 4, number of input streams
- LOG_N_STREAMS, 2, width of stream index
- WIDTH, 32, message word width
- LOG_MAX_PACKET_LENGTH, 10, width of header length field
- WEIGHT_WIDTH, 4, width of each per-stream weight
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_data  in  WIDTH*N_STREAMS  stream i on bits [WIDTH*(i+1)-1 -: WIDTH]
- in_valid  in  N_STREAMS  stream i word present
- in_ready  out  N_STREAMS  combinational; word of stream i accepted when in_valid[i] && in_ready[i]
- in_weights  in  WEIGHT_WIDTH*N_STREAMS  packets per turn, stream i on bits [WEIGHT_WIDTH*(i+1)-1 -: WEIGHT_WIDTH]; used only with MSA_WEIGHTED_EN
- out_data  out  WIDTH  registered output word
- out_valid  out  1  registered; out_data valid
- out_ready  in  1  sink accepts word when out_valid && out_ready
- grant  out  N_STREAMS  registered one-hot current owner, 0 when idle
- error  out  1  registered one-cycle pulse on a protocol error

## Operation
- Header word: bit WIDTH-1 = 1; bits [WIDTH-2 -: LOG_MAX_PACKET_LENGTH] = L, the number of payload words following the header. L=0 means a header-only packet.
- in_ready[i] = grant[i] && state in {HEAD, BODY} && (!out_valid || out_ready). All other in_ready bits are 0.
- Every accepted word, including the header, is copied to out_data with out_valid=1 on the next cycle. When no word is accepted, out_valid clears once the held word is taken.
- FSM states:
  - IDLE: grant=0. If any in_valid bit is set, select the first valid stream at or after ptr, wrapping. Register grant to that stream; go to HEAD. If the selected stream differs from ptr, clear credit.
  - HEAD: on acceptance, if header bit = 1, capture L into remaining. If L=0, the packet is done; otherwise go to BODY.
  - HEAD, header bit = 0: drop the word (not forwarded), pulse error, return to IDLE. ptr and credit are unchanged.
  - BODY: each accepted word decrements remaining. The word accepted with remaining=1 ends the packet.
- Packet done:
  - Increment credit.
  - If the turn is exhausted: set ptr = grant index + 1 (N_STREAMS-1 wraps to 0), clear credit.
  - Otherwise ptr stays on the same stream.
  - grant clears and the FSM goes to IDLE.
- Header bit set on a BODY word: forwarded as payload, no error. Length governs framing.
- remaining is LOG_MAX_PACKET_LENGTH bits. Maximum L = 2^LOG_MAX_PACKET_LENGTH-1.

## Timing
- Reset values: out_data=0, out_valid=0, grant=0, error=0, state=IDLE, ptr=0, credit=0, remaining=0, in_ready=0.
- Grant latency: 1 cycle from in_valid in IDLE to grant and in_ready asserting.
- Data latency: 1 cycle from input acceptance to out_valid.
- Throughput: 1 word/cycle within a packet when out_ready=1.
- Inter-packet gap: 1 dead cycle (IDLE) between packets.
- A granted stream that deasserts in_valid mid-packet keeps the grant indefinitely. There is no preemption.
- out_ready=0 holds out_data/out_valid stable and drops in_ready; no words are lost.
- Reset asserted mid-packet clears everything immediately. The partial packet is truncated and out_valid falls asynchronously.

## Configuration
- MSA_WEIGHTED_EN defined:
  - The turn is exhausted when credit+1 >= in_weights[grant]. A weight of 0 is treated as 1.
  - in_weights is sampled in IDLE when grant is chosen.
- MSA_WEIGHTED_EN undefined:
  - Every turn is one packet.
  - in_weights is ignored and the credit register is not implemented.

## Test plan
- Single stream 0 sends header L=3 plus 3 words, out_ready=1:
  - grant=0001 one cycle after in_valid.
  - 4 words appear on consecutive cycles, 1 cycle after acceptance.
  - grant=0 after the last word.
- All 4 streams continuously valid, L=1 packets, weighting off: packet sources on out_data rotate 0,1,2,3,0 with one idle cycle between packets.
- MSA_WEIGHTED_EN, weights {1,2,0,3}, all streams valid: per round, packet order is 0,1,1,2,3,3,3.
- Stream 2 in HEAD presents 0x00000005 (header bit clear):
  - No out_valid for that word.
  - error pulses for one cycle.
  - Next grant goes to stream 2 again if it is valid.
- Toggle out_ready 1,0,0,1 during the body of an L=4 packet: no words are dropped or duplicated, out_data is held during stalls, and in_ready=0 while stalled.
- Assert rst during BODY with remaining=2: out_valid, grant and error go to 0 at once. After release, a new header on stream 1 is granted normally.
